// File: rtl/fetch_redirect.sv
// ---------------------------------------------------------------------------
// fetch_redirect
//   Instruction-fetch and PC-redirect stage. Owns the PC, issues one
//   instruction-memory request at a time, buffers one fetched instruction
//   towards decode, and turns the execute-stage branch/jump outcome into a
//   PC redirect plus a flush of younger work.
//
// Ports
//   clk, reset             clock (rising edge), async active-high reset
//   ex_valid_i .. ex_rs1_i execute-stage instruction, comparator flags,
//                          PC, immediate and JALR base
//   imem_req_o/addr_o      request valid / address (one outstanding max)
//   imem_gnt_i             request accepted this cycle
//   imem_rvalid_i/rdata_i  response valid / instruction word
//   if_valid_o/pc_o/insn_o buffered instruction towards decode
//   if_ready_i             decode accepts the buffer
//   taken_o/target_o       combinational redirect and its target
//   flush_o                combinational, equal to taken_o
// ---------------------------------------------------------------------------
module fetch_redirect #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  input  logic [DWIDTH-1:0] ex_imm_i,
  input  logic [DWIDTH-1:0] ex_rs1_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              if_valid_o,
  output logic [AWIDTH-1:0] if_pc_o,
  output logic [DWIDTH-1:0] if_insn_o,
  input  logic              if_ready_i,
  output logic              taken_o,
  output logic [AWIDTH-1:0] target_o,
  output logic              flush_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD} state_t;

  state_t            state;
  logic [AWIDTH-1:0] pc;
  logic              drop;   // the outstanding response belongs to a squashed fetch

  logic [AWIDTH-1:0] pc_rel_sum;
  logic [AWIDTH-1:0] jalr_sum;

  // -------------------------------------------------------------------------
  // Taken decision and target (execute-stage resolution)
  // -------------------------------------------------------------------------
  assign pc_rel_sum = ex_pc_i + ex_imm_i[AWIDTH-1:0];
  assign jalr_sum   = ex_rs1_i[AWIDTH-1:0] + ex_imm_i[AWIDTH-1:0];

  always_comb begin
    // NOTE: default first so every path assigns taken_o and no latch is inferred.
    taken_o = 1'b0;
    if (ex_valid_i && !reset) begin
      case (ex_opcode_i)
        OP_BRANCH: begin
          case (ex_funct3_i)
            3'b000:         taken_o = breq_i;
            3'b001:         taken_o = !breq_i;
            3'b100, 3'b110: taken_o = brlt_i;
            3'b101, 3'b111: taken_o = !brlt_i;
            default:        taken_o = 1'b0;
          endcase
        end
        OP_JAL, OP_JALR: taken_o = 1'b1;
        default:         taken_o = 1'b0;
      endcase
    end
  end

  // JALR clears bit 0 of the sum; branches and JAL are PC-relative.
  assign target_o = (ex_opcode_i == OP_JALR) ? (jalr_sum & ~AWIDTH'(1)) : pc_rel_sum;
  assign flush_o  = taken_o;

  // The request is a decode of the registered state; reset forces it low.
  assign imem_req_o  = (state == ST_REQ) && !reset;
  assign imem_addr_o = pc;

  // -------------------------------------------------------------------------
  // Fetch FSM, PC and decode buffer
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_REQ;
      pc         <= BASEADDR;
      drop       <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= BASEADDR;
      if_insn_o  <= NOP;
    end else if (taken_o) begin
      // A redirect outranks every other event this cycle.
      pc         <= target_o;
      if_valid_o <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_gnt_i) begin
            state <= ST_WAIT;
            drop  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            state <= ST_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_gnt_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              if_insn_o  <= imem_rdata_i;
              if_pc_o    <= pc;
              if_valid_o <= 1'b1;
              pc         <= pc + AWIDTH'(4);
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (if_ready_i) begin
            if_valid_o <= 1'b0;
            state      <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Instruction-fetch and PC-redirect stage of the pipeline.
- Owns the PC register and drives a valid/grant/rvalid instruction-memory request interface.
- Buffers one fetched instruction towards decode with a valid/ready handshake.
- Consumes the execute-stage comparison flags (breq/brlt) with opcode/funct3 to decide branch/jump taken, compute the target, redirect the PC and flush younger work.

Parameters:
- DWIDTH, 32, data/instruction width.
- AWIDTH, 32, address width.
- BASEADDR, 32'h0100_0000, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  execute stage holds a valid instruction.
- ex_opcode_i  in  7  execute-stage opcode.
- ex_funct3_i  in  3  execute-stage funct3.
- breq_i  in  1  rs1 == rs2 from the comparator.
- brlt_i  in  1  rs1 < rs2 (signed or unsigned per funct3) from the comparator.
- ex_pc_i  in  AWIDTH  PC of the execute-stage instruction.
- ex_imm_i  in  DWIDTH  sign-extended immediate.
- ex_rs1_i  in  DWIDTH  rs1 value (JALR base).
- imem_req_o  out  1  memory request valid.
- imem_addr_o  out  AWIDTH  request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  DWIDTH  response instruction.
- if_valid_o  out  1  fetched instruction available.
- if_pc_o  out  AWIDTH  PC of the buffered instruction.
- if_insn_o  out  DWIDTH  buffered instruction.
- if_ready_i  in  1  decode accepts the buffer.
- taken_o  out  1  combinational: redirect this cycle.
- target_o  out  AWIDTH  combinational redirect target.
- flush_o  out  1  combinational, equal to taken_o; younger stages squash.

Behaviour:
- Taken decode, valid only when ex_valid_i=1 and reset=0:
  - Opcode 1100011, by funct3:
    - 000: breq.
    - 001: !breq.
    - 100 and 110: brlt.
    - 101 and 111: !brlt.
    - 010 and 011: never taken.
  - Opcode 1101111 (JAL): always taken.
  - Opcode 1100111 (JALR): always taken.
  - All other opcodes: not taken.
- Target:
  - Branch and JAL: ex_pc_i + ex_imm_i, modulo 2^AWIDTH.
  - JALR: (ex_rs1_i + ex_imm_i) with bit 0 cleared.
  - target_o is don't-care when taken_o=0.
- Reset values:
  - pc = BASEADDR; state = REQ; drop = 0.
  - imem_req_o=0 while reset is asserted.
  - if_valid_o=0, if_pc_o=BASEADDR, if_insn_o=32'h0000_0013 (NOP).
  - taken_o=0, flush_o=0.
- FSM states: REQ, WAIT, HOLD.
  - REQ:
    - imem_req_o=1, imem_addr_o=pc.
    - On imem_gnt_i, go to WAIT.
    - Without a grant, the address may change only on a redirect; an ungranted request may be withdrawn.
  - WAIT:
    - imem_req_o=0.
    - On imem_rvalid_i with drop=0: load if_insn_o=imem_rdata_i, load if_pc_o=pc, set if_valid_o=1, set pc=pc+4, go to HOLD.
    - On imem_rvalid_i with drop=1: discard the data, clear drop, go to REQ.
  - HOLD:
    - if_valid_o stays high and the buffer stays stable until if_valid_o && if_ready_i.
    - On acceptance: clear if_valid_o and go to REQ; the next request is issued in the following cycle.
- Redirect (taken_o=1) has priority over all other events in the same cycle:
  - pc <= target_o.
  - if_valid_o <= 0, even if if_ready_i=1 that cycle.
  - In REQ without a grant: stay in REQ; the next request uses the target.
  - In REQ with a grant that cycle: go to WAIT with drop=1.
  - In WAIT without rvalid: drop=1.
  - In WAIT with rvalid the same cycle: discard the data and go to REQ.
  - In HOLD: go to REQ.
- Back-to-back redirects: the last one wins; drop never exceeds one outstanding response.
- Only one memory request is ever outstanding.
- A stray rvalid in REQ or HOLD is ignored.
- Latency, reset release to if_valid_o: first request in cycle 0; with gnt in cycle 0 and rvalid in cycle 1, if_valid_o is high in cycle 2.
- Reset asserted mid-transaction:
  - All state returns to its reset values immediately.
  - A late rvalid after release arrives in REQ and is ignored.
- pc+4 wraps modulo 2^AWIDTH.

Test Plan:
- Reset release with gnt=1 and rvalid 1 cycle later (rdata=32'h0050_0093), if_ready=1 -> addr 0x0100_0000; if_valid high 2 cycles after release with if_pc=0x0100_0000; next request to 0x0100_0004.
- BEQ with breq=1, ex_pc=0x0100_0010, imm=-8; BNE with breq=1; BGEU with brlt=0 -> taken, target 0x0100_0008, flush_o high that cycle; not taken; taken.
- JALR with rs1=0x0100_0101, imm=4, while in WAIT -> target 0x0100_0104; the pending response is dropped; the next request goes to 0x0100_0104 and no stale if_valid occurs.
- if_ready=0 for 5 cycles in HOLD -> if_insn/if_pc stable, imem_req_o=0 throughout; the request resumes the cycle after acceptance.
- Redirect in the same cycle as if_ready=1 in HOLD -> the buffer is not delivered (if_valid falls); the next fetch goes to the target.
- Reset pulsed while in WAIT, then rvalid arrives after release -> outputs at reset values; the stray data is ignored; fetch restarts at BASEADDR.
